dac_spi_arbiter: RTL and testbench

Shares one DAC `spi_master` between two requesters: the control loop (port 0) and the host/CPU register path (port 1). It grants the bus to one requester at a time and drives the master's arm/to_slave inputs. It returns the master's read-back word and a finished flag to the granted requester, then inserts a guard gap before the next transaction. It sits between `control_loop`/host logic and the single DAC `spi_master` instance.

---
 rtl/dac_spi_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dac_spi_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_arbiter.sv
// dac_spi_arbiter: shares one DAC spi_master between the control loop (port 0)
// and the host register path (port 1). It grants one port at a time, returns
// the read-back word, and then holds the bus idle for a guard gap.
// Build option: define DAC_SPI_ARBITER_ROUND_ROBIN_EN for round-robin tie
// breaking. When it is undefined, port 0 always wins a tie.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | bus free; grant the next request
// RUN     | master armed for the owner; waiting for master_finished
// RELEASE | owner's finished held high until the owner drops arm
// GUARD   | bus held idle GUARD_CYCLES cycles before the next grant
module dac_spi_arbiter #(
   parameter int WID          = 24,
   parameter int GUARD_CYCLES = 2,
   parameter int GUARD_LEN    = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           arm_0,
   input  logic           arm_1,
   input  logic [WID-1:0] to_slave_0,
   input  logic [WID-1:0] to_slave_1,
   output logic [WID-1:0] from_slave_0,
   output logic [WID-1:0] from_slave_1,
   output logic           finished_0,
   output logic           finished_1,
   output logic           master_arm,
   output logic [WID-1:0] master_to_slave,
   input  logic [WID-1:0] master_from_slave,
   input  logic           master_finished,
   output logic           grant,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, RUN, RELEASE, GUARD} state_t;

   state_t               state_q, state_d;
   logic                 grant_q, grant_d;
   logic                 master_arm_q, master_arm_d;
   logic [WID-1:0]       mts_q, mts_d;
   logic [WID-1:0]       fs0_q, fs0_d;
   logic [WID-1:0]       fs1_q, fs1_d;
   logic                 fin0_q, fin0_d;
   logic                 fin1_q, fin1_d;
   logic [GUARD_LEN-1:0] guard_q, guard_d;
   logic                 win;
   logic                 owner_arm;
`ifdef DAC_SPI_ARBITER_ROUND_ROBIN_EN
   logic                 last_q, last_d;
`endif

   // State and output registers; reset clears everything, including mid-transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         master_arm_q <= 1'b0;
         mts_q        <= '0;
         fs0_q        <= '0;
         fs1_q        <= '0;
         fin0_q       <= 1'b0;
         fin1_q       <= 1'b0;
         guard_q      <= '0;
`ifdef DAC_SPI_ARBITER_ROUND_ROBIN_EN
         last_q       <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         master_arm_q <= master_arm_d;
         mts_q        <= mts_d;
         fs0_q        <= fs0_d;
         fs1_q        <= fs1_d;
         fin0_q       <= fin0_d;
         fin1_q       <= fin1_d;
         guard_q      <= guard_d;
`ifdef DAC_SPI_ARBITER_ROUND_ROBIN_EN
         last_q       <= last_d;
`endif
      end
   end

   // Winner selection, next-state logic and registered output updates.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      master_arm_d = master_arm_q;
      mts_d        = mts_q;
      fs0_d        = fs0_q;
      fs1_d        = fs1_q;
      fin0_d       = fin0_q;
      fin1_d       = fin1_q;
      guard_d      = guard_q;
`ifdef DAC_SPI_ARBITER_ROUND_ROBIN_EN
      last_d       = last_q;
      win          = (arm_0 && arm_1) ? ~last_q : arm_1;
`else
      win          = ~arm_0;
`endif
      owner_arm    = grant_q ? arm_1 : arm_0;

      case (state_q)
         IDLE: begin
            if (arm_0 || arm_1) begin
               grant_d      = win;
               mts_d        = win ? to_slave_1 : to_slave_0;
               master_arm_d = 1'b1;
               state_d      = RUN;
`ifdef DAC_SPI_ARBITER_ROUND_ROBIN_EN
               last_d       = win;
`endif
            end
         end
         RUN: begin
            if (master_finished) begin
               master_arm_d = 1'b0;
               if (owner_arm) begin
                  if (grant_q) begin
                     fs1_d  = master_from_slave;
                     fin1_d = 1'b1;
                  end else begin
                     fs0_d  = master_from_slave;
                     fin0_d = 1'b1;
                  end
                  state_d = RELEASE;
               end else begin
                  // Owner aborted: the word is discarded, the bus still rests.
                  guard_d = GUARD_LEN'(GUARD_CYCLES);
                  state_d = GUARD;
               end
            end
         end
         RELEASE: begin
            if (!owner_arm) begin
               fin0_d  = 1'b0;
               fin1_d  = 1'b0;
               guard_d = GUARD_LEN'(GUARD_CYCLES);
               state_d = GUARD;
            end
         end
         GUARD: begin
            guard_d = guard_q - 1'b1;
            if (guard_q <= GUARD_LEN'(1)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant           = grant_q;
   assign master_arm      = master_arm_q;
   assign master_to_slave = mts_q;
   assign from_slave_0    = fs0_q;
   assign from_slave_1    = fs1_q;
   assign finished_0      = fin0_q;
   assign finished_1      = fin1_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Testbench for dac_spi_arbiter: a cycle table with directly driven master
// handshake, then model-driven sequences for slow release and contention.
module tb_dac_spi_arbiter;

   localparam int G = 2;

   logic        clk, rst, arm_0, arm_1, master_finished;
   logic [23:0] to_slave_0, to_slave_1, master_from_slave;
   logic [23:0] from_slave_0, from_slave_1, master_to_slave;
   logic        finished_0, finished_1, master_arm, grant, busy;

   int checks = 0;
   int failures = 0;

   // Simple spi_master model: finished mlat cycles after arm, held until arm drops.
   logic        model_en = 1'b0;
   int          mlat = 5;
   int          mcnt = 0;

   dac_spi_arbiter #(.WID(24), .GUARD_CYCLES(G), .GUARD_LEN(4)) dut (
      .clk(clk), .rst(rst),
      .arm_0(arm_0), .arm_1(arm_1),
      .to_slave_0(to_slave_0), .to_slave_1(to_slave_1),
      .from_slave_0(from_slave_0), .from_slave_1(from_slave_1),
      .finished_0(finished_0), .finished_1(finished_1),
      .master_arm(master_arm), .master_to_slave(master_to_slave),
      .master_from_slave(master_from_slave), .master_finished(master_finished),
      .grant(grant), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst, a0, a1;
      logic [23:0] t0, t1;
      logic        mf;
      logic [23:0] mfs;
      logic        ema;
      logic [23:0] emts;
      logic        ef0, ef1;
      logic [23:0] efs0, efs1;
      logic        eg, eb;
   } vec_t;

   vec_t tv[25];

   function automatic vec_t mk(input logic r, a0, a1, input logic [23:0] t0, t1,
                               input logic mf, input logic [23:0] mfs,
                               input logic ema, input logic [23:0] emts,
                               input logic ef0, ef1, input logic [23:0] efs0, efs1,
                               input logic eg, eb);
      vec_t v;
      v.rst = r; v.a0 = a0; v.a1 = a1; v.t0 = t0; v.t1 = t1; v.mf = mf; v.mfs = mfs;
      v.ema = ema; v.emts = emts; v.ef0 = ef0; v.ef1 = ef1;
      v.efs0 = efs0; v.efs1 = efs1; v.eg = eg; v.eb = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to the next falling edge, then let the master model react.
   task automatic step();
      @(negedge clk);
      if (model_en) begin
         if (!master_arm) begin
            master_finished = 1'b0;
            mcnt = 0;
         end else if (!master_finished) begin
            mcnt++;
            if (mcnt >= mlat) begin
               master_finished   = 1'b1;
               master_from_slave = ~master_to_slave;
            end
         end
      end
   endtask

   logic [23:0] exp_word;
   logic [23:0] old_fs1;
   logic        ok;
   int          n, gcount, low_cnt;
   logic        prev_ma;
   logic        exp_order[4];

   initial begin
      rst = 1'b1; arm_0 = 1'b0; arm_1 = 1'b0;
      to_slave_0 = '0; to_slave_1 = '0;
      master_finished = 1'b0; master_from_slave = '0;

      //         rst a0 a1 t0          t1          mf mfs         | ma mts        f0 f1 fs0         fs1         g  b
      tv[0]  = mk(1, 0, 0, 24'h0,      24'h0,      0, 24'h0,        0, 24'h0,      0, 0, 24'h0,      24'h0,      0, 0);
      tv[1]  = mk(0, 1, 0, 24'h100000, 24'h0,      0, 24'h0,        1, 24'h100000, 0, 0, 24'h0,      24'h0,      0, 1);
      tv[2]  = mk(0, 1, 0, 24'h123456, 24'h0,      0, 24'h0,        1, 24'h100000, 0, 0, 24'h0,      24'h0,      0, 1);
      tv[3]  = mk(0, 1, 0, 24'h123456, 24'h0,      1, 24'hABCDEF,   0, 24'h100000, 1, 0, 24'hABCDEF, 24'h0,      0, 1);
      tv[4]  = mk(0, 1, 0, 24'h123456, 24'h0,      0, 24'h0,        0, 24'h100000, 1, 0, 24'hABCDEF, 24'h0,      0, 1);
      tv[5]  = mk(0, 0, 0, 24'h0,      24'h0,      0, 24'h0,        0, 24'h100000, 0, 0, 24'hABCDEF, 24'h0,      0, 1);
      tv[6]  = mk(0, 0, 1, 24'h0,      24'h00AAAA, 0, 24'h0,        0, 24'h100000, 0, 0, 24'hABCDEF, 24'h0,      0, 1);
      tv[7]  = mk(0, 0, 1, 24'h0,      24'h00AAAA, 0, 24'h0,        0, 24'h100000, 0, 0, 24'hABCDEF, 24'h0,      0, 0);
      tv[8]  = mk(0, 0, 1, 24'h0,      24'h00AAAA, 0, 24'h0,        1, 24'h00AAAA, 0, 0, 24'hABCDEF, 24'h0,      1, 1);
      tv[9]  = mk(0, 0, 1, 24'h0,      24'h00AAAA, 1, 24'h555555,   0, 24'h00AAAA, 0, 1, 24'hABCDEF, 24'h555555, 1, 1);
      tv[10] = mk(0, 0, 0, 24'h0,      24'h0,      0, 24'h0,        0, 24'h00AAAA, 0, 0, 24'hABCDEF, 24'h555555, 1, 1);
      tv[11] = mk(0, 0, 0, 24'h0,      24'h0,      0, 24'h0,        0, 24'h00AAAA, 0, 0, 24'hABCDEF, 24'h555555, 1, 1);
      tv[12] = mk(0, 0, 0, 24'h0,      24'h0,      0, 24'h0,        0, 24'h00AAAA, 0, 0, 24'hABCDEF, 24'h555555, 1, 0);
      tv[13] = mk(0, 0, 1, 24'h0,      24'h0F0F0F, 0, 24'h0,        1, 24'h0F0F0F, 0, 0, 24'hABCDEF, 24'h555555, 1, 1);
      tv[14] = mk(0, 0, 0, 24'h0,      24'h0F0F0F, 0, 24'h0,        1, 24'h0F0F0F, 0, 0, 24'hABCDEF, 24'h555555, 1, 1);
      tv[15] = mk(0, 0, 0, 24'h0,      24'h0F0F0F, 1, 24'h999999,   0, 24'h0F0F0F, 0, 0, 24'hABCDEF, 24'h555555, 1, 1);
      tv[16] = mk(0, 0, 0, 24'h0,      24'h0,      0, 24'h0,        0, 24'h0F0F0F, 0, 0, 24'hABCDEF, 24'h555555, 1, 1);
      tv[17] = mk(0, 0, 0, 24'h0,      24'h0,      0, 24'h0,        0, 24'h0F0F0F, 0, 0, 24'hABCDEF, 24'h555555, 1, 0);
      tv[18] = mk(0, 1, 0, 24'h000001, 24'h0,      0, 24'h0,        1, 24'h000001, 0, 0, 24'hABCDEF, 24'h555555, 0, 1);
      tv[19] = mk(1, 1, 0, 24'h000001, 24'h0,      0, 24'h0,        0, 24'h0,      0, 0, 24'h0,      24'h0,      0, 0);
      tv[20] = mk(0, 0, 1, 24'h0,      24'h222222, 0, 24'h0,        1, 24'h222222, 0, 0, 24'h0,      24'h0,      1, 1);
      tv[21] = mk(0, 0, 1, 24'h0,      24'h222222, 1, 24'h333333,   0, 24'h222222, 0, 1, 24'h0,      24'h333333, 1, 1);
      tv[22] = mk(0, 0, 0, 24'h0,      24'h0,      0, 24'h0,        0, 24'h222222, 0, 0, 24'h0,      24'h333333, 1, 1);
      tv[23] = mk(0, 0, 0, 24'h0,      24'h0,      0, 24'h0,        0, 24'h222222, 0, 0, 24'h0,      24'h333333, 1, 1);
      tv[24] = mk(0, 0, 0, 24'h0,      24'h0,      0, 24'h0,        0, 24'h222222, 0, 0, 24'h0,      24'h333333, 1, 0);

      step();
      for (int i = 0; i < 25; i++) begin
         rst = tv[i].rst; arm_0 = tv[i].a0; arm_1 = tv[i].a1;
         to_slave_0 = tv[i].t0; to_slave_1 = tv[i].t1;
         master_finished = tv[i].mf; master_from_slave = tv[i].mfs;
         step();
         chk($sformatf("v%0d master_arm", i),      32'(master_arm),      32'(tv[i].ema));
         chk($sformatf("v%0d master_to_slave", i), 32'(master_to_slave), 32'(tv[i].emts));
         chk($sformatf("v%0d finished_0", i),      32'(finished_0),      32'(tv[i].ef0));
         chk($sformatf("v%0d finished_1", i),      32'(finished_1),      32'(tv[i].ef1));
         chk($sformatf("v%0d from_slave_0", i),    32'(from_slave_0),    32'(tv[i].efs0));
         chk($sformatf("v%0d from_slave_1", i),    32'(from_slave_1),    32'(tv[i].efs1));
         chk($sformatf("v%0d grant", i),           32'(grant),           32'(tv[i].eg));
         chk($sformatf("v%0d busy", i),            32'(busy),            32'(tv[i].eb));
      end

      // Slow release with stable latch; port 1 waits for the full guard.
      master_finished = 1'b0; master_from_slave = '0;
      model_en = 1'b1; mlat = 30;
      arm_0 = 1'b1; to_slave_0 = 24'h000001;
      step();
      chk("slow grant latency", 32'(master_arm), 32'd1);
      chk("slow grant port", 32'(grant), 32'd0);
      to_slave_0 = 24'hFFFFFF;
      arm_1 = 1'b1; to_slave_1 = 24'h0C0C0C;
      ok = 1'b1; n = 0;
      while (!finished_0 && n < 100) begin
         if (master_to_slave !== 24'h000001) ok = 1'b0;
         if (finished_1) ok = 1'b0;
         step();
         n++;
      end
      chk("slow finished_0 seen", 32'(finished_0), 32'd1);
      chk("stable latch through run", 32'(ok), 32'd1);
      exp_word = 24'hFFFFFE;
      chk("slow from_slave_0", 32'(from_slave_0), 32'(exp_word));
      chk("slow master_arm dropped", 32'(master_arm), 32'd0);
      ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (!finished_0 || master_arm || finished_1) ok = 1'b0;
         step();
      end
      chk("slow finished_0 held", 32'(ok), 32'd1);
      arm_0 = 1'b0;
      n = 0;
      while (!master_arm && n < 20) begin
         step();
         n++;
      end
      chk("slow guard to port1 grant cycles", 32'(n), 32'(G + 2));
      chk("slow port1 granted", 32'(grant), 32'd1);
      chk("slow finished_0 cleared", 32'(finished_0), 32'd0);
      n = 0;
      while (!finished_1 && n < 100) begin
         step();
         n++;
      end
      exp_word = 24'hF3F3F3;
      chk("slow from_slave_1", 32'(from_slave_1), 32'(exp_word));
      arm_1 = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         step();
         n++;
      end
      chk("slow back to idle", 32'(busy), 32'd0);

      // Abort with the model: master_arm held until master_finished.
      mlat = 8;
      old_fs1 = from_slave_1;
      arm_1 = 1'b1; to_slave_1 = 24'h444444;
      step();
      for (int c = 0; c < 5; c++) step();
      arm_1 = 1'b0;
      ok = 1'b1; n = 0;
      while (!master_finished && n < 50) begin
         if (!master_arm) ok = 1'b0;
         step();
         n++;
      end
      chk("abort master_arm held", 32'(ok), 32'd1);
      ok = 1'b1; n = 0;
      while (n < 10) begin
         if (finished_1) ok = 1'b0;
         step();
         n++;
      end
      chk("abort finished_1 never", 32'(ok), 32'd1);
      chk("abort from_slave_1 kept", 32'(from_slave_1), 32'(old_fs1));
      chk("abort back to idle", 32'(busy), 32'd0);

      // Contention: both ports request and re-request.
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("contention reset busy", 32'(busy), 32'd0);
      chk("contention reset master_arm", 32'(master_arm), 32'd0);
`ifdef DAC_SPI_ARBITER_ROUND_ROBIN_EN
      exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
`else
      exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b0; exp_order[3] = 1'b0;
`endif
      mlat = 5;
      arm_0 = 1'b1; arm_1 = 1'b1;
      to_slave_0 = 24'h0A0000; to_slave_1 = 24'h0B0000;
      gcount = 0; low_cnt = 0; prev_ma = 1'b0; n = 0; ok = 1'b1;
      while (gcount < 4 && n < 2000) begin
         step();
         n++;
         if (master_arm && !prev_ma) begin
            chk($sformatf("contention grant %0d", gcount), 32'(grant), 32'(exp_order[gcount]));
            if (gcount > 0) begin
               checks++;
               if (low_cnt < G + 1) begin
                  failures++;
                  $display("FAIL contention gap %0d: got %0d cycles required at least %0d",
                           gcount, low_cnt, G + 1);
               end
            end
            gcount++;
         end
         if (master_arm) low_cnt = 0;
         else low_cnt++;
         prev_ma = master_arm;
         if ((finished_0 && grant != 1'b0) || (finished_1 && grant != 1'b1)) ok = 1'b0;
         if (finished_0 && arm_0) begin
            exp_word = ~to_slave_0;
            chk("contention from_slave_0", 32'(from_slave_0), 32'(exp_word));
            arm_0 = 1'b0;
         end else if (!arm_0) begin
            arm_0 = 1'b1;
            to_slave_0 = to_slave_0 + 24'd1;
         end
         if (finished_1 && arm_1) begin
            exp_word = ~to_slave_1;
            chk("contention from_slave_1", 32'(from_slave_1), 32'(exp_word));
            arm_1 = 1'b0;
         end else if (!arm_1) begin
            arm_1 = 1'b1;
            to_slave_1 = to_slave_1 + 24'd1;
         end
      end
      chk("contention grants seen", 32'(gcount), 32'd4);
      chk("contention non-owner finished", 32'(ok), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
